// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic barrel shifter: one register per log2 shift stage,
// largest shift first, valid/ready stream handshake with full backpressure.
module pipelined_barrel_shifter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [1:0]       mode;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t       stg [SHW];
  stage_t       src [SHW];
  stage_t       nxt [SHW];
  logic [SHW:0] rdy;

  // A stage can load when it is empty or its successor is taking its beat.
  always_comb begin
    rdy      = '0;
    rdy[SHW] = out_ready;
    for (int k = int'(SHW) - 1; k >= 0; k--) begin
      rdy[k] = !stg[k].valid || rdy[k+1];
    end
  end

  always_comb begin
    src[0] = '{valid: in_valid, sign: in_data[WIDTH-1], mode: in_mode,
               shamt: in_shamt, data: in_data};
    for (int k = 1; k < int'(SHW); k++) begin
      src[k] = stg[k-1];
    end
  end

  // Stage k shifts by 2^(SHW-1-k); that power of two is also the shamt bit it tests.
  always_comb begin
    int unsigned sh;
    sh = 0;
    for (int k = 0; k < int'(SHW); k++) begin
      nxt[k] = src[k];
      sh     = 32'd1 << (SHW - 1 - k);
      if (|(src[k].shamt & SHW'(sh))) begin
        case (src[k].mode)
          MODE_LSR: nxt[k].data = src[k].data >> sh;
          MODE_ASR: nxt[k].data = (src[k].data >> sh) |
                                  ({WIDTH{src[k].sign}} << (WIDTH - sh));
          MODE_LSL: nxt[k].data = src[k].data << sh;
          MODE_ROR: nxt[k].data = (src[k].data >> sh) |
                                  (src[k].data << (WIDTH - sh));
          default:  nxt[k].data = src[k].data;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(SHW); k++) begin
      if (!rst_n) begin
        stg[k] <= '0;
      end else if (rdy[k]) begin
        stg[k] <= nxt[k];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = stg[SHW-1].valid;
  assign out_data  = stg[SHW-1].data;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and scoreboard checks of pipelined_barrel_shifter at WIDTH 8, 16 and 32.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] in_shamt;
  logic [1:0] in_mode;

  logic        b16_in_valid, b16_in_ready, b16_out_valid, b16_out_ready;
  logic [15:0] b16_in_data, b16_out_data;
  logic [3:0]  b16_in_shamt;
  logic [1:0]  b16_in_mode;

  logic        b32_in_valid, b32_in_ready, b32_out_valid, b32_out_ready;
  logic [31:0] b32_in_data, b32_out_data;
  logic [4:0]  b32_in_shamt;
  logic [1:0]  b32_in_mode;

  pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  pipelined_barrel_shifter #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(b16_in_valid), .in_ready(b16_in_ready),
    .in_data(b16_in_data), .in_shamt(b16_in_shamt), .in_mode(b16_in_mode),
    .out_valid(b16_out_valid), .out_ready(b16_out_ready), .out_data(b16_out_data));

  pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(b32_in_valid), .in_ready(b32_in_ready),
    .in_data(b32_in_data), .in_shamt(b32_in_shamt), .in_mode(b32_in_mode),
    .out_valid(b32_out_valid), .out_ready(b32_out_ready), .out_data(b32_out_data));

  // Whole-word reference: shift the full operand at once, then mask to w bits.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                            input logic [1:0] m, input int w);
    logic [31:0] mask, x, r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    x    = d & mask;
    case (m)
      2'b00:   r = x >> sh;
      2'b01:   r = (x >> sh) | (x[w-1] ? (mask & ~(mask >> sh)) : 32'd0);
      2'b10:   r = (x << sh) & mask;
      default: r = ((x >> sh) | (x << (w - sh))) & mask;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF; in_shamt = 3'd1; in_mode = 2'b11; out_ready = 1'b1;
    b16_in_valid = 1'b1; b16_in_data = 16'hFFFF; b16_in_shamt = 4'd1; b16_in_mode = 2'b00;
    b16_out_ready = 1'b1;
    b32_in_valid = 1'b1; b32_in_data = 32'hFFFF_FFFF; b32_in_shamt = 5'd1; b32_in_mode = 2'b00;
    b32_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got %h expected 00", out_data); end
    checks++; if (b16_out_valid !== 1'b0 || b16_out_data !== 16'h0) begin failures++; $display("FAIL reset_w16 got %b/%h expected 0/0000", b16_out_valid, b16_out_data); end
    checks++; if (b32_out_valid !== 1'b0 || b32_out_data !== 32'h0) begin failures++; $display("FAIL reset_w32 got %b/%h expected 0/00000000", b32_out_valid, b32_out_data); end
    rst_n = 1'b1;
    in_valid = 1'b0; b16_in_valid = 1'b0; b32_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_no_ghost cycle %0d got %b expected 0", c, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_modes();
    logic [2:0] sh_tab  [8];
    logic [7:0] exp_tab [8];
    sh_tab  = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
    exp_tab = '{8'h16, 8'hF6, 8'hA0, 8'h96, 8'hB4, 8'hB4, 8'hB4, 8'hB4};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 8'hB4; in_shamt = sh_tab[i]; in_mode = 2'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== (j == 2)) begin
          failures++; $display("FAIL mode_latency vec %0d cycle %0d got %b expected %b", i, j + 1, out_valid, (j == 2));
        end
      end
      checks++;
      if (out_data !== exp_tab[i]) begin
        failures++; $display("FAIL mode_data vec %0d mode %0d shamt %0d got %h expected %h", i, i % 4, sh_tab[i], out_data, exp_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
    @(posedge clk); #1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_data = 8'h81; in_shamt = 3'(c); in_mode = 2'b11;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cycle %0d got %b expected 1", c, in_ready); end
      end
      checks++;
      if (out_valid !== (c >= 3)) begin failures++; $display("FAIL stream_out_valid cycle %0d got %b expected %b", c, out_valid, (c >= 3)); end
      if (c >= 3) begin
        checks++;
        if (out_data !== exp_tab[c-3]) begin failures++; $display("FAIL stream_data beat %0d got %h expected %h", c - 3, out_data, exp_tab[c-3]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] q[$];
    logic [7:0] held;
    int sent = 0;
    int got = 0;
    bit saw_full = 1'b0;
    bit stalled = 1'b0;
    held = 8'h00;
    @(posedge clk); #1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = !(c >= 3 && c < 7);
      if (sent < 6) begin
        in_valid = 1'b1; in_data = 8'h3C + 8'(sent * 17); in_shamt = 3'(sent + 1); in_mode = 2'(sent);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (stalled) begin
        checks++; if (out_data !== held) begin failures++; $display("FAIL bp_hold cycle %0d got %h expected %h", c, out_data, held); end
      end
      if (!in_ready) saw_full = 1'b1;
      if (in_valid && in_ready) begin
        q.push_back(8'(ref_shift(32'(in_data), int'(in_shamt), in_mode, 8)));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0 || out_data !== q[0]) begin
          failures++; $display("FAIL bp_data beat %0d got %h expected %h", got, out_data, (q.size() == 0) ? 8'hxx : q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    checks++; if (got != 6 || q.size() != 0) begin failures++; $display("FAIL bp_count got %0d left %0d expected 6 and 0", got, q.size()); end
    checks++; if (!saw_full) begin failures++; $display("FAIL bp_in_ready_low got never-low expected low when full"); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_duplicate cycle %0d got %b expected 0", c, out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hFF; in_shamt = 3'd0; in_mode = 2'b00;
    @(posedge clk); #1;
    in_data = 8'hEE;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_flush got %b expected 0", out_valid); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_ghost cycle %0d got %b expected 0", c, out_valid); end
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hB4; in_shamt = 3'd1; in_mode = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (out_valid !== (j == 2)) begin failures++; $display("FAIL midrst_latency cycle %0d got %b expected %b", j + 1, out_valid, (j == 2)); end
    end
    checks++; if (out_data !== 8'h5A) begin failures++; $display("FAIL midrst_data got %h expected 5a", out_data); end
  endtask

  task automatic test_sweep();
    localparam int N = 10000;
    logic [15:0] q16[$];
    logic [31:0] q32[$];
    logic [15:0] e16, first16;
    logic [31:0] e32, first32;
    int lat16 = 0, lat32 = 0;
    int sent16 = 0, sent32 = 0, got16 = 0, got32 = 0;
    first16 = '0; first32 = '0;
    @(posedge clk); #1;
    b16_in_valid = 1'b1; b16_in_data = 16'hC3A5; b16_in_shamt = 4'd9; b16_in_mode = 2'b01;
    b32_in_valid = 1'b1; b32_in_data = 32'h8001_F00D; b32_in_shamt = 5'd17; b32_in_mode = 2'b11;
    e16 = 16'(ref_shift(32'hC3A5, 9, 2'b01, 16));
    e32 = ref_shift(32'h8001_F00D, 17, 2'b11, 32);
    @(posedge clk); #1;
    b16_in_valid = 1'b0; b32_in_valid = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (b16_out_valid && lat16 == 0) begin lat16 = j + 1; first16 = b16_out_data; end
      if (b32_out_valid && lat32 == 0) begin lat32 = j + 1; first32 = b32_out_data; end
    end
    checks++; if (lat16 != 4) begin failures++; $display("FAIL w16_latency got %0d expected 4", lat16); end
    checks++; if (lat32 != 5) begin failures++; $display("FAIL w32_latency got %0d expected 5", lat32); end
    checks++; if (first16 !== e16) begin failures++; $display("FAIL w16_first got %h expected %h", first16, e16); end
    checks++; if (first32 !== e32) begin failures++; $display("FAIL w32_first got %h expected %h", first32, e32); end

    @(posedge clk); #1;
    for (int c = 0; c < 40000 && (got16 < N || got32 < N); c++) begin
      b16_in_valid  = (sent16 < N) && ($urandom_range(9) != 0);
      b16_in_data   = 16'($urandom);
      b16_in_shamt  = 4'($urandom);
      b16_in_mode   = 2'($urandom);
      b16_out_ready = ($urandom_range(4) != 0);
      b32_in_valid  = (sent32 < N) && ($urandom_range(9) != 0);
      b32_in_data   = $urandom;
      b32_in_shamt  = 5'($urandom);
      b32_in_mode   = 2'($urandom);
      b32_out_ready = ($urandom_range(4) != 0);
      @(negedge clk);
      if (b16_in_valid && b16_in_ready) begin
        q16.push_back(16'(ref_shift(32'(b16_in_data), int'(b16_in_shamt), b16_in_mode, 16)));
        sent16++;
      end
      if (b16_out_valid && b16_out_ready) begin
        checks++;
        if (q16.size() == 0 || b16_out_data !== q16[0]) begin
          failures++; $display("FAIL w16_data beat %0d got %h expected %h", got16, b16_out_data, (q16.size() == 0) ? 16'hxxxx : q16[0]);
        end
        if (q16.size() != 0) void'(q16.pop_front());
        got16++;
      end
      if (b32_in_valid && b32_in_ready) begin
        q32.push_back(ref_shift(b32_in_data, int'(b32_in_shamt), b32_in_mode, 32));
        sent32++;
      end
      if (b32_out_valid && b32_out_ready) begin
        checks++;
        if (q32.size() == 0 || b32_out_data !== q32[0]) begin
          failures++; $display("FAIL w32_data beat %0d got %h expected %h", got32, b32_out_data, (q32.size() == 0) ? 32'hxxxx_xxxx : q32[0]);
        end
        if (q32.size() != 0) void'(q32.pop_front());
        got32++;
      end
      @(posedge clk); #1;
    end
    b16_in_valid = 1'b0; b32_in_valid = 1'b0; b16_out_ready = 1'b1; b32_out_ready = 1'b1;
    checks++; if (got16 != N || q16.size() != 0) begin failures++; $display("FAIL w16_count got %0d left %0d expected %0d and 0", got16, q16.size(), N); end
    checks++; if (got32 != N || q32.size() != 0) begin failures++; $display("FAIL w32_count got %0d left %0d expected %0d and 0", got32, q32.size(), N); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
